reg_stack: RTL and testbench
============================

# reg_stack

Hardware LIFO stack for the 16-bit microprocessor. The datapath pushes register values onto it (CALL, PUSH) and reads them back (RET, POP). It is the read-back counterpart of the single loadable register: words go in with `push` and come back out, last-in first-out, on a registered `out`. The block sits beside the register bank and is driven directly by the control unit.

## Interface
- `WIDTH`, 16, data word width.
- `DEPTH`, 16, total entries including the top-of-stack register; must be ≥ 2.
- `AW`, $clog2(DEPTH), index width; the count is `AW+1` bits.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push`  in  1  write `in` as the new top of stack.
- `pop`  in  1  discard the current top; the entry below becomes the top.
- `in`  in  WIDTH  data to push.
- `out`  out  WIDTH  registered top of stack; 0 when empty.
- `count`  out  AW+1  number of valid entries, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `overflow`  out  1  sticky; set by a push that was rejected because the stack was full.
- `underflow`  out  1  sticky; set by a pop that was rejected because the stack was empty.
- `clear_err`  in  1  clears both sticky flags.

## Operation
- Storage: the top entry lives in the `out` register. The entries below it live in a `DEPTH-1` word array indexed 0..count-2, with 0 at the bottom.
- Push only, not full: if `count > 0`, write array[count-1] with `out`; then `out` takes `in` and `count` increments.
- Push only, full: ignored; `out`, `count` and the array are unchanged; `overflow` is set.
- Pop only, `count ≥ 2`: `out` takes array[count-2]; `count` decrements.
- Pop only, `count == 1`: `out` becomes 0; `count` becomes 0.
- Pop only, empty: ignored; `underflow` is set; `out` stays 0.
- Push and pop together, not empty: replace the top. `out` takes `in`, `count` is unchanged, the array is untouched, no flag is set (this includes the full case).
- Push and pop together, empty: behaves as push only; no underflow.
- `clear_err` on the same edge that raises a flag: the new error wins, so the flag reads 1 after that edge.
- `empty` and `full` are decoded combinationally from `count`.

## Timing
- Reset (asynchronous assert, takes effect immediately): `out` = 0, `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `underflow` = 0. Array contents are not reset and are don't-care.
- Latency is 1 cycle. A push sampled at edge N makes `out == in` visible after edge N. A pop at edge N shows the new top after edge N.
- Back-to-back push/pop on every cycle is supported with no bubbles.
- Reset asserted mid-sequence discards all entries. The first push after deassertion sees `count` = 0.

## Structure
- Shared package `cpu_pkg`: `WORD_W = 16`, `STACK_DEPTH = 16`, and the `word_t` typedef.
- One sub-module, `stack_mem`: a `DEPTH-1` × `WIDTH` array with one synchronous write port and one asynchronous read port. Top-of-stack logic, counter and flags stay in `reg_stack`.

## Test plan
- Reset, then push 16'haa11, 16'h5555, 16'h1234 -> `out` = 16'h1234, `count` = 3; three pops return 16'h5555, 16'haa11, 0 with `count` 2, 1, 0 and `empty` = 1.
- Fill 16 pushes of 0..15 -> `full` = 1, `out` = 15. A 17th push (16'hffff) -> `out` = 15, `count` = 16, `overflow` = 1. Pulse `clear_err` -> `overflow` = 0.
- Pop when empty -> `out` = 0, `count` = 0, `underflow` = 1. It stays 1 through later pushes until `clear_err`.
- Push+pop together with `count` = 2 and top 16'h5555, `in` = 16'h00ff -> `out` = 16'h00ff, `count` = 2. A following pop exposes the original bottom entry.
- Push+pop together when empty with `in` = 16'h0042 -> `out` = 16'h0042, `count` = 1, `underflow` = 0. Push+pop when full -> top replaced, `overflow` = 0.
- Assert `reset` mid-cycle with `count` = 5 -> all outputs go to reset values immediately. A push of 16'h0001 after release -> `count` = 1, a pop -> `out` = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: shared word width, stack depth and word type for the 16-bit CPU.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;
  localparam int WORD_W      = 16;
  localparam int STACK_DEPTH = 16;

  typedef logic [WORD_W-1:0] word_t;
endpackage

`default_nettype wire

// File: rtl/stack_mem.sv
// ---------------------------------------------------------------------------
// stack_mem: backing store for the entries below top-of-stack; one
// synchronous write port, one asynchronous read port.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stack_mem #(
  parameter int WIDTH   = 16,
  parameter int ENTRIES = 15,
  parameter int AW      = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/reg_stack.sv
// ---------------------------------------------------------------------------
// reg_stack: LIFO with the top entry held in the registered output; deeper
// entries spill into stack_mem.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = STACK_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] TWO  = (AW+1)'(2);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic             replace;
  logic             mem_wr_en;
  logic [AW-1:0]    mem_wr_addr;
  logic [AW-1:0]    mem_rd_addr;
  logic [WIDTH-1:0] mem_rd_data;

  assign empty   = (count == '0);
  assign full    = (count == FULL);
  assign replace = push && pop && !empty;

  // The old top spills into the array only on a real push onto a non-empty stack.
  assign mem_wr_en   = push && !replace && !full && !empty;
  assign mem_wr_addr = AW'(count - ONE);
  assign mem_rd_addr = AW'(count - TWO);

  stack_mem #(
    .WIDTH   (WIDTH),
    .ENTRIES (DEPTH - 1),
    .AW      (AW)
  ) u_stack_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (mem_wr_addr),
    .wr_data (out),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Flag sets below come later, so a new error beats clear_err on the same edge.
      if (clear_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (replace) begin
        out <= in;
      end else if (push) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          out   <= in;
          count <= count + ONE;
        end
      end else if (pop) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          out   <= (count > ONE) ? mem_rd_data : '0;
          count <= count - ONE;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_stack.sv
// ---------------------------------------------------------------------------
// tb_reg_stack: directed vector table plus hand-written corner sequences.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reg_stack;

  logic        clk;
  logic        reset;
  logic        push;
  logic        pop;
  logic [15:0] in;
  logic [15:0] out;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;
  logic        clear_err;

  int total = 0;
  int bad   = 0;

  reg_stack dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .in        (in),
    .out       (out),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .clear_err (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic        pop;
    logic        clr;
    logic [15:0] din;
    logic [15:0] eout;
    logic [4:0]  ecnt;
    logic        eovf;
    logic        eunf;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic pu, logic po, logic cl, logic [15:0] d,
                              logic [15:0] eo, logic [4:0] ec, logic ov, logic un);
    vec_t v;
    v.push = pu; v.pop = po; v.clr = cl; v.din = d;
    v.eout = eo; v.ecnt = ec; v.eovf = ov; v.eunf = un;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [15:0] eo, logic [4:0] ec, logic ov, logic un);
    check({tag, " out"},       32'(out),       32'(eo));
    check({tag, " count"},     32'(count),     32'(ec));
    check({tag, " empty"},     32'(empty),     32'(ec == 5'd0));
    check({tag, " full"},      32'(full),      32'(ec == 5'd16));
    check({tag, " overflow"},  32'(overflow),  32'(ov));
    check({tag, " underflow"}, 32'(underflow), 32'(un));
  endtask

  // Drive one cycle of inputs on the falling edge; outputs settle after the rising edge.
  task automatic step(logic pu, logic po, logic cl, logic [15:0] d);
    @(negedge clk);
    push = pu; pop = po; clear_err = cl; in = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear_err = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 16'haa11, 16'haa11, 5'd1, 0, 0);
    tbl[1]  = mk(1, 0, 0, 16'h5555, 16'h5555, 5'd2, 0, 0);
    tbl[2]  = mk(1, 0, 0, 16'h1234, 16'h1234, 5'd3, 0, 0);
    tbl[3]  = mk(0, 1, 0, 16'h0000, 16'h5555, 5'd2, 0, 0);
    tbl[4]  = mk(0, 1, 0, 16'h0000, 16'haa11, 5'd1, 0, 0);
    tbl[5]  = mk(0, 1, 0, 16'h0000, 16'h0000, 5'd0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 16'h0000, 16'h0000, 5'd0, 0, 1);
    tbl[7]  = mk(1, 0, 0, 16'h0007, 16'h0007, 5'd1, 0, 1);
    tbl[8]  = mk(1, 0, 0, 16'h0008, 16'h0008, 5'd2, 0, 1);
    tbl[9]  = mk(0, 0, 1, 16'h0000, 16'h0008, 5'd2, 0, 0);
    tbl[10] = mk(0, 1, 0, 16'h0000, 16'h0007, 5'd1, 0, 0);
    tbl[11] = mk(1, 0, 0, 16'h5555, 16'h5555, 5'd2, 0, 0);
    tbl[12] = mk(1, 1, 0, 16'h00ff, 16'h00ff, 5'd2, 0, 0);
    tbl[13] = mk(0, 1, 0, 16'h0000, 16'h0007, 5'd1, 0, 0);
    tbl[14] = mk(0, 1, 0, 16'h0000, 16'h0000, 5'd0, 0, 0);
    tbl[15] = mk(1, 1, 0, 16'h0042, 16'h0042, 5'd1, 0, 0);

    reset = 1'b1; push = 1'b0; pop = 1'b0; clear_err = 1'b0; in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 16'h0000, 5'd0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].din);
      check_all($sformatf("vec%0d", i), tbl[i].eout, tbl[i].ecnt, tbl[i].eovf, tbl[i].eunf);
    end

    step(0, 1, 0, 16'h0000);
    check_all("drain", 16'h0000, 5'd0, 0, 0);

    // Fill to capacity with 0..15.
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 16'(i));
      check(($sformatf("fill%0d out", i)), 32'(out), 32'(i));
      check(($sformatf("fill%0d count", i)), 32'(count), 32'(i + 1));
    end
    check_all("filled", 16'd15, 5'd16, 0, 0);

    step(1, 0, 0, 16'hffff);
    check_all("push full", 16'd15, 5'd16, 1, 0);
    step(0, 0, 1, 16'h0000);
    check_all("clear ovf", 16'd15, 5'd16, 0, 0);

    step(1, 1, 0, 16'h0abc);
    check_all("replace full", 16'h0abc, 5'd16, 0, 0);
    step(0, 1, 0, 16'h0000);
    check_all("pop after replace", 16'd14, 5'd15, 0, 0);
    step(1, 0, 0, 16'h0def);
    check_all("refill", 16'h0def, 5'd16, 0, 0);
    step(1, 0, 1, 16'hbeef);
    check_all("clr vs new ovf", 16'h0def, 5'd16, 1, 0);
    step(0, 0, 1, 16'h0000);
    check_all("clear ovf2", 16'h0def, 5'd16, 0, 0);

    // Unwind the whole stack to confirm every spilled entry survived.
    step(0, 1, 0, 16'h0000);
    check_all("unwind top", 16'd14, 5'd15, 0, 0);
    for (int i = 13; i >= 0; i--) begin
      step(0, 1, 0, 16'h0000);
      check(($sformatf("unwind%0d out", i)), 32'(out), 32'(i));
    end
    step(0, 1, 0, 16'h0000);
    check_all("unwound", 16'h0000, 5'd0, 0, 0);

    // Asynchronous reset in the middle of a cycle with five entries held.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0100 + 16'(i));
    check_all("five", 16'h0104, 5'd5, 0, 0);
    step(0, 1, 0, 16'h0000);
    step(0, 1, 0, 16'h0000);
    step(1, 0, 0, 16'h0200);
    step(1, 0, 0, 16'h0201);
    check_all("five again", 16'h0201, 5'd5, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_all("mid reset", 16'h0000, 5'd0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 16'h0001);
    check_all("post reset push", 16'h0001, 5'd1, 0, 0);
    step(0, 1, 0, 16'h0000);
    check_all("post reset pop", 16'h0000, 5'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
